serial_word_collector: RTL
==========================

Name: serial_word_collector

Overview:
- Receive side for the 8-bit shift-style datapath: rebuilds parallel words from a serial bit stream.
- Bits arrive one per valid cycle, least-significant first by default, matching the shift direction `{bit, word[7:1]}` used by the word transmitter.
- Each completed word sits in a one-entry output buffer and is released with a valid/ready handshake.
- Sits between the serial link and any parallel consumer; provides frame realignment and a sticky overflow flag.

Parameters:
WIDTH, 8, bits per word (legal range 2..32)
LSB_FIRST, 1, 1 = first received bit lands in bit 0; 0 = first received bit lands in bit WIDTH-1

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
in_bit  input  1  serial data bit
in_vld  input  1  in_bit is valid this cycle
in_sof  input  1  start of frame, qualified by in_vld: this bit is bit 0 of a new word
out_word  output  WIDTH  assembled word, stable while out_vld=1 and out_rdy=0
out_vld  output  1  out_word holds an unconsumed word
out_rdy  input  1  consumer accepts out_word when out_vld & out_rdy
overflow  output  1  sticky: a completed word was dropped
clr_ovf  input  1  clears overflow
bit_cnt  output  $clog2(WIDTH)  bits collected so far in the current word (debug/trace)

Behaviour:
- Reset, synchronous on clk when rst=1:
  - out_word=0, out_vld=0, overflow=0, bit_cnt=0, shift register=0.
  - rst has priority over every other input in the same cycle.
  - A partially collected word is discarded.
- Shift, on in_vld=1:
  - LSB_FIRST=1: sh <= {in_bit, sh[WIDTH-1:1]}.
  - LSB_FIRST=0: sh <= {sh[WIDTH-2:0], in_bit}.
  - bit_cnt increments; when it reaches WIDTH-1, the word completes on that bit.
  - No shift and no count change on cycles with in_vld=0. Gaps of any length are allowed.
- Realignment:
  - in_vld & in_sof forces this bit to be bit 0: bit_cnt restarts at 1 after the cycle.
  - Any partial word is silently dropped. overflow is not set.
  - in_sof with in_vld=0 is ignored.
  - With WIDTH bits, sof on the bit that would have been bit 0 anyway is a no-op.
- Completion: the completed word value includes the bit received this cycle; bit_cnt wraps to 0.
- Output buffer states:
  - EMPTY (out_vld=0):
    - A completion loads out_word and moves to FULL.
    - out_vld is asserted the cycle after the last bit arrives (latency 1).
  - FULL (out_vld=1):
    - out_vld & out_rdy with no completion in the same cycle → EMPTY.
    - Consume and completion in the same cycle → stay FULL and load the new word (no bubble, full throughput).
    - Completion without out_rdy → word dropped, out_word unchanged, overflow <= 1.
- Overflow:
  - Sticky. clr_ovf=1 clears it.
  - If clr_ovf and a new drop occur in the same cycle, set wins (overflow=1).
- out_word changes only on a load. It never changes while FULL and not consumed.
- Arithmetic: bit_cnt wraps modulo WIDTH. For non-power-of-2 WIDTH, compare explicitly with WIDTH-1; do not rely on natural wrap.

Decomposition:
- Shared package holds:
  - default WIDTH constant (8);
  - a bit-order enum (LSB_FIRST/MSB_FIRST) mirrored by the transmitter;
  - a function returning the counter width ($clog2 with a floor of 1).
- One sub-module: word_hold_buf, the one-entry valid/ready buffer.
  - Ports: clk, rst, load, load_data, out_word, out_vld, out_rdy, drop.
  - Holds the EMPTY/FULL logic.
- Shifter and counter stay in the top.

Test Plan:
- Basic word: after reset, send bits 1,0,1,1,0,0,1,0 on consecutive cycles with out_rdy=1 → out_vld=1 for exactly one cycle, the cycle after the 8th bit, with out_word=8'h4D. overflow=0.
- Back-to-back with gaps: send 0xA5 then 0x3C with in_vld toggling 1/0, out_rdy=1 → two single-cycle out_vld pulses with out_word 0xA5 then 0x3C. bit_cnt reads 0 between words.
- Backpressure and overflow: out_rdy=0; send 0x11 then 0x22.
  - out_word stays 0x11; overflow=1 one cycle after the 16th bit.
  - Raise out_rdy → 0x11 consumed, out_vld=0.
  - Pulse clr_ovf → overflow=0.
  - Then hold clr_ovf=1 while a third dropped word completes → overflow=1.
- Simultaneous consume and load: out_rdy=0 with 0x55 held; raise out_rdy on the same cycle the last bit of 0xAA arrives → next cycle out_vld=1, out_word=0xAA, overflow=0.
- Realignment: send 3 bits, then in_sof=1 with bits of 0xC3 → out_word=0xC3, bit_cnt=1 after the sof bit, no overflow. Repeat with LSB_FIRST=0 and the same bit sequence → out_word=bit-reversed 0xC3=0xC3; use 0x81→0x81 and 0x01→0x80.
- Reset mid-word: send 5 bits, assert rst for one cycle while out_vld=1 → out_vld=0, out_word=0, overflow=0, bit_cnt=0. The next 8 bits produce exactly one clean word.

Source files
------------

// File: rtl/serial_word_collector_pkg.sv
// Shared definitions for the serial word datapath: default word width,
// bit-order encoding shared with the transmitter, and counter sizing.
package serial_word_collector_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic {
    ORDER_LSB_FIRST = 1'b0,
    ORDER_MSB_FIRST = 1'b1
  } bit_order_e;

  typedef enum logic {
    BUF_EMPTY = 1'b0,
    BUF_FULL  = 1'b1
  } buf_state_e;

  // Bit counter width; never narrower than one bit.
  function automatic int cnt_width(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/serial_word_collector_hold_buf.sv
// One-entry valid/ready output buffer. A load while full and not being
// consumed is dropped and reported on the drop pulse.
module word_hold_buf
  import serial_word_collector_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  output logic [WIDTH-1:0] out_word,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic             drop
);

  buf_state_e       state_q, state_d;
  logic [WIDTH-1:0] word_q, word_d;

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    drop    = 1'b0;
    unique case (state_q)
      BUF_EMPTY: begin
        if (load) begin
          state_d = BUF_FULL;
          word_d  = load_data;
        end
      end
      BUF_FULL: begin
        // Consume and load together keeps the buffer full with no bubble.
        if (load && out_rdy) begin
          word_d = load_data;
        end else if (load) begin
          drop = 1'b1;
        end else if (out_rdy) begin
          state_d = BUF_EMPTY;
        end
      end
      default: state_d = BUF_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= BUF_EMPTY;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
    end
  end

  assign out_word = word_q;
  assign out_vld  = (state_q == BUF_FULL);

endmodule

// File: rtl/serial_word_collector.sv
// Serial-to-parallel word collector with start-of-frame realignment,
// a one-entry output buffer and a sticky overflow flag.
module serial_word_collector
  import serial_word_collector_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int LSB_FIRST = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_bit,
  input  logic                        in_vld,
  input  logic                        in_sof,
  output logic [WIDTH-1:0]            out_word,
  output logic                        out_vld,
  input  logic                        out_rdy,
  output logic                        overflow,
  input  logic                        clr_ovf,
  output logic [cnt_width(WIDTH)-1:0] bit_cnt
);

  localparam int             CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
  localparam bit_order_e     ORDER    = (LSB_FIRST != 0) ? ORDER_LSB_FIRST : ORDER_MSB_FIRST;

  logic [WIDTH-1:0] sh_q, sh_d, shifted;
  logic [CW-1:0]    cnt_q, cnt_d, cnt_base;
  logic             done;
  logic             ovf_q, ovf_d;
  logic             drop;

  generate
    if (ORDER == ORDER_LSB_FIRST) begin : g_lsb
      assign shifted = {in_bit, sh_q[WIDTH-1:1]};
    end else begin : g_msb
      assign shifted = {sh_q[WIDTH-2:0], in_bit};
    end
  endgenerate

  always_comb begin
    sh_d  = sh_q;
    cnt_d = cnt_q;
    done  = 1'b0;
    // A start-of-frame bit is always bit 0, whatever was collected before.
    cnt_base = in_sof ? '0 : cnt_q;
    if (in_vld) begin
      sh_d = shifted;
      if (cnt_base == CNT_LAST) begin
        done  = 1'b1;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_base + CNT_ONE;
      end
    end
  end

  // A fresh drop beats a simultaneous clear.
  assign ovf_d = drop ? 1'b1 : (clr_ovf ? 1'b0 : ovf_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      sh_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      sh_q  <= sh_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  word_hold_buf #(.WIDTH(WIDTH)) u_buf (
    .clk       (clk),
    .rst       (rst),
    .load      (done),
    .load_data (sh_d),
    .out_word  (out_word),
    .out_vld   (out_vld),
    .out_rdy   (out_rdy),
    .drop      (drop)
  );

  assign overflow = ovf_q;
  assign bit_cnt  = cnt_q;

endmodule
